lcd_cmd_scheduler: RTL
======================

// Module: lcd_cmd_scheduler
// PURPOSE
//   Buffers image-op commands from a host and issues them one at a time to the LCD image controller.
//   Paces each issue on the controller's busy flag and sequences a frame: ops first, then write-back (cmd 0).
//   Sits between the host/testbench command source and the LCD controller's cmd/cmd_valid/busy/done ports.
//   Reports completion, per-frame op count and errors.
// PARAMETERS
//   DEPTH    4     command FIFO entries; power of two, >= 2
//   AW       2     log2(DEPTH), FIFO pointer width
//   TIMEOUT  1023  max cycles to wait on lcd_busy low or lcd_done before abort (10-bit watchdog)
// PORTS
//   clk            in   1   single clock, rising edge
//   reset_n        in   1   asynchronous active-low reset
//   host_cmd       in   4   command code: 0 = write-back/end of frame; 1-11 = ops; 12-15 illegal
//   host_valid     in   1   host_cmd valid; transfer happens when host_valid && host_ready
//   host_ready     out  1   FIFO can accept (combinational: !full)
//   lcd_cmd        out  4   command to LCD controller (registered)
//   lcd_cmd_valid  out  1   one-cycle issue strobe (registered)
//   lcd_busy       in   1   LCD controller busy; commands are issued only while low
//   lcd_done       in   1   LCD controller write-back complete pulse
//   seq_active     out  1   high in any state other than IDLE
//   frame_done     out  1   one-cycle pulse on accepted lcd_done
//   op_count       out  8   non-zero commands issued in the current frame; saturates at 255
//   err_illegal    out  1   sticky: an illegal code (12-15) was offered and dropped
//   err_timeout    out  1   sticky: watchdog expired
// BEHAVIOUR
//   Reset: every output register 0; FIFO empty; state IDLE; watchdog 0. host_ready is 1 because the FIFO is empty.
//   FIFO push: on host_valid && host_ready.
//     Codes 12-15 are accepted (ready honoured) but not stored; err_illegal is set.
//     When full, host_ready = 0; a simultaneous pop does not open ready in the same cycle.
//   FSM states:
//     IDLE      : if FIFO non-empty -> WAIT_RDY.
//     WAIT_RDY  : watchdog counts up.
//                 If lcd_busy == 0: pop the head, register lcd_cmd = head and lcd_cmd_valid = 1 for the next cycle -> ISSUE.
//     ISSUE     : lcd_cmd_valid high for exactly this cycle; watchdog cleared.
//                 If lcd_cmd != 0, op_count += 1 (saturating) -> GUARD; if lcd_cmd == 0 -> WAIT_DONE.
//     GUARD     : one cycle; lcd_busy is ignored because the controller's busy is registered.
//                 If FIFO non-empty -> WAIT_RDY, else -> IDLE.
//     WAIT_DONE : watchdog counts up.
//                 On lcd_done: frame_done pulses next cycle, op_count clears to 0 -> IDLE.
//                 Commands pushed meanwhile stay queued for the next frame.
//   Issue latency: issue cycle is exactly 1 cycle after busy is seen low in WAIT_RDY.
//     Minimum spacing between two issues is 3 cycles: ISSUE, GUARD, WAIT_RDY.
//   Watchdog: 10-bit counter, active only in WAIT_RDY and WAIT_DONE.
//     Reaching TIMEOUT sets err_timeout, flushes the FIFO, clears op_count -> IDLE.
//     No frame_done pulse is generated on timeout.
//   lcd_cmd holds its last value when lcd_cmd_valid is low.
//   Sticky errors clear only on reset.
//   Reset mid-operation: state, FIFO and all counters return to reset values in the same cycle; no strobe is emitted.
// TESTING
//   1. Reset, push {4,5,0}, busy low -> three lcd_cmd_valid strobes with cmd 4,5,0, each >=3 cycles apart;
//      lcd_done -> frame_done pulse; op_count 2 then 0.
//   2. Fill FIFO with 4 entries while lcd_busy = 1 -> host_ready = 0 on the 5th offer;
//      busy low -> issues in FIFO order 1,2,3,4.
//   3. Push code 13 between 7 and 0 -> only 7,0 issued; err_illegal = 1 and stays 1.
//   4. Hold lcd_busy = 1 for 1023 cycles with a queued cmd -> err_timeout = 1, FIFO empty, state IDLE, no strobe.
//   5. Drop busy in the cycle right after a strobe -> no second strobe in GUARD;
//      next strobe exactly 2 cycles after GUARD.
//   6. Assert reset_n low mid-WAIT_DONE with 2 queued cmds -> all outputs 0, host_ready 1,
//      no stale issue after release.

Source files
------------

// File: rtl/lcd_cmd_scheduler.sv
// Queues host image-op commands and issues them one at a time to the LCD controller, closing each frame with write-back (cmd 0).
// Issue strobe lands 1 cycle after busy is seen low, >= 3 cycles apart; host_ready drops only while the FIFO is full.
module lcd_cmd_scheduler #(
   parameter int DEPTH   = 4,
   parameter int AW      = 2,
   parameter int TIMEOUT = 1023
) (
   input  logic       i_clk,
   input  logic       i_reset_n,
   input  logic [3:0] i_host_cmd,
   input  logic       i_host_valid,
   output logic       o_host_ready,
   output logic [3:0] o_lcd_cmd,
   output logic       o_lcd_cmd_valid,
   input  logic       i_lcd_busy,
   input  logic       i_lcd_done,
   output logic       o_seq_active,
   output logic       o_frame_done,
   output logic [7:0] o_op_count,
   output logic       o_err_illegal,
   output logic       o_err_timeout
);
   localparam logic [2:0] S_IDLE      = 3'd0;
   localparam logic [2:0] S_WAIT_RDY  = 3'd1;
   localparam logic [2:0] S_ISSUE     = 3'd2;
   localparam logic [2:0] S_GUARD     = 3'd3;
   localparam logic [2:0] S_WAIT_DONE = 3'd4;
   localparam logic [AW:0] LP_DEPTH   = DEPTH[AW:0];
   localparam logic [9:0]  LP_TIMEOUT = TIMEOUT[9:0];

   logic [3:0]    r_mem [DEPTH];
   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [AW:0]   r_count;
   logic [2:0]    r_state;
   logic [9:0]    r_wdog;
   logic [3:0]    r_lcd_cmd;
   logic          r_lcd_cmd_valid;
   logic          r_frame_done;
   logic [7:0]    r_op_count;
   logic          r_err_illegal;
   logic          r_err_timeout;

   logic          w_full;
   logic          w_empty;
   logic          w_accept;
   logic          w_illegal;
   logic          w_push;
   logic          w_pop;
   logic          w_waiting;
   logic          w_wd_hit;
   logic          w_timeout;
   logic [9:0]    w_wdog_next;
   logic [3:0]    w_head;

   assign w_full      = (r_count == LP_DEPTH);
   assign w_empty     = (r_count == '0);
   assign w_accept    = i_host_valid && !w_full;
   assign w_illegal   = (i_host_cmd >= 4'd12);
   assign w_push      = w_accept && !w_illegal;
   assign w_pop       = (r_state == S_WAIT_RDY) && !i_lcd_busy && !w_empty;
   assign w_head      = r_mem[r_rd_ptr];
   assign w_waiting   = (r_state == S_WAIT_RDY) || (r_state == S_WAIT_DONE);
   assign w_wdog_next = r_wdog + 10'd1;
   assign w_wd_hit    = (w_wdog_next == LP_TIMEOUT);
   // Progress (issue or done) in the expiry cycle wins over the watchdog.
   assign w_timeout   = ((r_state == S_WAIT_RDY)  && !w_pop      && w_wd_hit) ||
                        ((r_state == S_WAIT_DONE) && !i_lcd_done && w_wd_hit);

   always_ff @(posedge i_clk) begin
      if (w_push) r_mem[r_wr_ptr] <= i_host_cmd;
   end

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else if (w_timeout) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + (AW+1)'(1);
            2'b01:   r_count <= r_count - (AW+1)'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_state         <= S_IDLE;
         r_wdog          <= '0;
         r_lcd_cmd       <= '0;
         r_lcd_cmd_valid <= 1'b0;
         r_frame_done    <= 1'b0;
         r_op_count      <= '0;
         r_err_illegal   <= 1'b0;
         r_err_timeout   <= 1'b0;
      end else begin
         r_lcd_cmd_valid <= 1'b0;
         r_frame_done    <= 1'b0;
         r_wdog          <= (w_waiting && !w_timeout) ? w_wdog_next : 10'd0;
         if (w_accept && w_illegal) r_err_illegal <= 1'b1;
         if (w_timeout) begin
            r_err_timeout <= 1'b1;
            r_op_count    <= '0;
         end
         case (r_state)
            S_IDLE: begin
               if (!w_empty) r_state <= S_WAIT_RDY;
            end
            S_WAIT_RDY: begin
               if (w_pop) begin
                  r_lcd_cmd       <= w_head;
                  r_lcd_cmd_valid <= 1'b1;
                  r_state         <= S_ISSUE;
               end else if (w_timeout) begin
                  r_state <= S_IDLE;
               end
            end
            S_ISSUE: begin
               if (r_lcd_cmd != 4'd0) begin
                  if (r_op_count != 8'hFF) r_op_count <= r_op_count + 8'd1;
                  r_state <= S_GUARD;
               end else begin
                  r_state <= S_WAIT_DONE;
               end
            end
            // Controller busy lags the strobe by a cycle, so it is not trusted here.
            S_GUARD: begin
               r_state <= w_empty ? S_IDLE : S_WAIT_RDY;
            end
            S_WAIT_DONE: begin
               if (i_lcd_done) begin
                  r_frame_done <= 1'b1;
                  r_op_count   <= '0;
                  r_state      <= S_IDLE;
               end else if (w_timeout) begin
                  r_state <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign o_host_ready    = !w_full;
   assign o_lcd_cmd       = r_lcd_cmd;
   assign o_lcd_cmd_valid = r_lcd_cmd_valid;
   assign o_seq_active    = (r_state != S_IDLE);
   assign o_frame_done    = r_frame_done;
   assign o_op_count      = r_op_count;
   assign o_err_illegal   = r_err_illegal;
   assign o_err_timeout   = r_err_timeout;
endmodule
